rtc_bcd_core: RTL and testbench
===============================

Name: rtc_bcd_core

Overview:
Parametrised timekeeping core, the successor to the fixed 50 MHz / 12-hour clock.
- Counts seconds, minutes and hours directly in packed BCD, so no downstream binary-to-BCD stage is needed.
- Supports 12-hour or 24-hour mode and any input clock rate.
- A button-driven set FSM (mode/increment) replaces the separate set_hr/set_min/AM2PM strobes.
- Sits between the board keys and the card7seg digit decoders.

Parameters:
CLK_HZ, 50_000_000, input clock frequency; prescaler terminal count is CLK_HZ-1 (must be >= 2).
H24, 0, 0 = 12-hour with pm flag, 1 = 24-hour (pm held 0).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
run_en  in  1  1 = timekeeping advances; 0 = prescaler and time frozen
btn_mode  in  1  raw level, high while pressed, debounced upstream; rising edge cycles the set state
btn_inc  in  1  raw level, high while pressed, debounced upstream; rising edge increments the selected field
sec_bcd  out  8  seconds, {tens,units} BCD, 00-59
min_bcd  out  8  minutes, {tens,units} BCD, 00-59
hr_bcd  out  8  hours, BCD, 01-12 (H24=0) or 00-23 (H24=1)
pm  out  1  PM flag (H24=0 only)
field_sel  out  2  00 none, 01 hours, 10 minutes being set
tick_1hz  out  1  one-cycle pulse on each prescaler terminal count

Behaviour:
- Reset (async, rst=0):
  - prescaler=0, state=RUN, sec_bcd=8'h00, min_bcd=8'h00, pm=0.
  - hr_bcd=8'h12 (H24=0) or 8'h00 (H24=1).
  - field_sel=0, tick_1hz=0.
  - Applies mid-operation immediately, regardless of state.
- Button inputs:
  - Each passes a 2-flop synchroniser, then a rising-edge detector.
  - An action occurs 3 clk after the input rises.
  - Holding a button gives exactly one action.
- Prescaler:
  - Increments when run_en=1 and state=RUN.
  - At CLK_HZ-1 it wraps to 0 and tick_1hz pulses in that same cycle.
  - Time fields update on the clock edge after the tick.
- Carry chain on tick:
  - sec 59->00 carries into min; min 59->00 carries into hr.
  - H24=1: hr 23->00.
  - H24=0: hr 12->01; 11->12 toggles pm. Midnight is 12 AM, noon is 12 PM.
  - All fields update in one cycle; 11:59:59 PM -> 12:00:00 AM.
- BCD rule: the units digit wraps 9->0 with carry to tens; a tens digit above its maximum never appears.
- FSM states RUN, SET_HR, SET_MIN:
  - A mode edge steps RUN->SET_HR->SET_MIN->RUN.
  - Entering SET_HR clears the prescaler and sec_bcd to 00.
  - Leaving SET_MIN returns to RUN with the prescaler at 0, so the first tick comes CLK_HZ cycles later.
- Increment in SET states:
  - SET_HR: +1 with the hour wrap rules above (12h mode toggles pm on 11->12).
  - SET_MIN: +1, 59->00 with no carry into hr.
  - Increment in RUN is ignored.
- Simultaneous events:
  - mode and inc edges in the same cycle: mode wins, inc dropped.
  - While in SET states the prescaler does not run, so no tick can coincide.
- run_en=0: all counters hold, no tick; the set FSM still operates.
- field_sel decodes the state combinationally.

Optional Feature:
Macro RTC_ALARM_EN.
- Defined:
  - Adds states SET_AL_HR and SET_AL_MIN after SET_MIN; field_sel 01/10 with the new port al_active=1.
  - Alarm registers reset to hr 12 AM (H24=0) or 00 (H24=1), min 00.
  - Adds input alarm_arm and output alarm_ring.
  - alarm_ring sets on the tick that produces hr/pm/min equal to the alarm with sec=00, if alarm_arm=1.
  - alarm_ring clears on an inc edge in RUN, on alarm_arm=0, or on reset.
- Undefined: none of these ports, states or registers exist.

Decomposition:
- Package rtc_pkg holds:
  - state enum rtc_state_t;
  - BCD constants BCD_59, BCD_23, BCD_12, BCD_11, BCD_01;
  - function bcd_inc8 (packed 2-digit increment).
- Sub-module bcd_mod_counter: 2-digit BCD counter with MIN/MAX parameters, inc, load-to-MIN, wrap-out. It is instantiated for sec, min and hr, plus the alarm fields when the macro is defined.

Test Plan:
1. CLK_HZ=4, H24=0: reset -> 12:00:00 AM; after 4 cycles with run_en=1, tick_1hz pulses and then sec=01.
2. Preload 11:59:59 PM via the set FSM and run -> next tick gives 12:00:00, pm=0. With H24=1, 23:59:59 -> 00:00:00.
3. Mode press, inc x3 -> hr 12->01->02->03, sec=00. Mode, inc x61 -> min=01, hr unchanged. Mode -> RUN, first tick exactly 4 cycles later.
4. btn_mode and btn_inc rise in the same cycle in SET_HR -> state SET_MIN, hr unchanged. btn_inc held 100 cycles -> single increment.
5. run_en=0 for 20 cycles -> no tick, time constant. Assert rst mid-SET_MIN -> immediate reset values, state RUN.
6. RTC_ALARM_EN: alarm 12:01 AM armed, run from 12:00:58 -> alarm_ring high two ticks later; inc press -> ring clears.

Source files
------------

// File: rtl/rtc_bcd_core_pkg.sv
// rtc_pkg: shared state encoding, BCD constants and packed BCD increment for rtc_bcd_core
package rtc_pkg;
  typedef enum logic [2:0] {RUN, SET_HR, SET_MIN, SET_AL_HR, SET_AL_MIN} rtc_state_t;
  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_11 = 8'h11;
  localparam logic [7:0] BCD_01 = 8'h01;
  function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/rtc_bcd_core_if.sv
// rtc_bcd_core_if: board-side controls and BCD time outputs of rtc_bcd_core (alarm signals under RTC_ALARM_EN)
interface rtc_bcd_core_if;
  logic       run_en;
  logic       btn_mode;
  logic       btn_inc;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hr_bcd;
  logic       pm;
  logic [1:0] field_sel;
  logic       tick_1hz;
`ifdef RTC_ALARM_EN
  logic       alarm_arm;
  logic       alarm_ring;
  logic       al_active;
`endif
  modport master (
    output run_en, btn_mode, btn_inc,
`ifdef RTC_ALARM_EN
    output alarm_arm,
    input alarm_ring, al_active,
`endif
    input sec_bcd, min_bcd, hr_bcd, pm, field_sel, tick_1hz
  );
  modport slave (
    input run_en, btn_mode, btn_inc,
`ifdef RTC_ALARM_EN
    input alarm_arm,
    output alarm_ring, al_active,
`endif
    output sec_bcd, min_bcd, hr_bcd, pm, field_sel, tick_1hz
  );
endinterface

// File: rtl/rtc_bcd_core_bcd_mod_counter.sv
// bcd_mod_counter: two-digit packed BCD counter MIN..MAX with increment, load-to-MIN and wrap-out
module bcd_mod_counter import rtc_pkg::*; #(
  parameter logic [7:0] MIN = 8'h00,
  parameter logic [7:0] MAX = BCD_59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  output logic [7:0] q,
  output logic       wrap
);
  logic [7:0] q_q, q_d;
  // load wins over increment; wrap flags an increment taken at MAX
  always_comb begin
    q_d = load ? MIN : inc ? ((q_q == MAX) ? MIN : bcd_inc8(q_q)) : q_q;
    wrap = inc && (q_q == MAX);
  end
  // count register, cleared to MIN
  always_ff @(posedge clk or negedge rst)
    if (!rst) q_q <= MIN;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/rtc_bcd_core.sv
// rtc_bcd_core: BCD hh:mm:ss timekeeper with 12/24h modes and a mode/inc set FSM; RTC_ALARM_EN adds the alarm
module rtc_bcd_core import rtc_pkg::*; #(
  parameter int CLK_HZ = 50_000_000,
  parameter bit H24 = 1'b0
) (
  input logic           clk,
  input logic           rst,
  rtc_bcd_core_if.slave bus
);
  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] TC = PW'(CLK_HZ - 1);
  localparam logic [7:0] HR_MAX = H24 ? BCD_23 : BCD_11;
  rtc_state_t state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [2:0] mode_sync_q, mode_sync_d, inc_sync_q, inc_sync_d;
  logic pm_q, pm_d;
  logic mode_ev, inc_ev, inc_act, running, tick, sec_load;
  logic sec_wrap, min_wrap, hr_wrap, min_inc, hr_inc;
  logic [7:0] sec, min, hr;
  // button synchronisers and edge detect, prescaler next value
  always_comb begin
    mode_sync_d = {mode_sync_q[1:0], bus.btn_mode};
    inc_sync_d = {inc_sync_q[1:0], bus.btn_inc};
    mode_ev = mode_sync_q[1] & ~mode_sync_q[2];
    inc_ev = inc_sync_q[1] & ~inc_sync_q[2];
    inc_act = inc_ev & ~mode_ev;
    running = (state_q == RUN) && bus.run_en;
    tick = running && (cnt_q == TC);
    sec_load = mode_ev && (state_q == RUN);
    cnt_d = sec_load ? '0 : running ? (tick ? '0 : cnt_q + PW'(1)) : cnt_q;
  end
  // hours count 00..11 internally in 12h mode so the 11->12 step is the wrap that flips pm
  assign min_inc = (state_q == SET_MIN) ? inc_act : sec_wrap;
  assign hr_inc = (state_q == SET_HR) ? inc_act : (state_q == RUN) && min_wrap;
  assign pm_d = H24 ? 1'b0 : pm_q ^ hr_wrap;
  bcd_mod_counter #(.MAX(BCD_59)) u_sec (.clk(clk), .rst(rst), .inc(tick), .load(sec_load), .q(sec), .wrap(sec_wrap));
  bcd_mod_counter #(.MAX(BCD_59)) u_min (.clk(clk), .rst(rst), .inc(min_inc), .load(1'b0), .q(min), .wrap(min_wrap));
  bcd_mod_counter #(.MAX(HR_MAX)) u_hr (.clk(clk), .rst(rst), .inc(hr_inc), .load(1'b0), .q(hr), .wrap(hr_wrap));
  // set FSM state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= RUN;
    else state_q <= state_d;
  // each mode edge advances one field; inc edges never move the state
  always_comb begin
`ifdef RTC_ALARM_EN
    state_d = !mode_ev ? state_q : (state_q == RUN) ? SET_HR : (state_q == SET_HR) ? SET_MIN :
              (state_q == SET_MIN) ? SET_AL_HR : (state_q == SET_AL_HR) ? SET_AL_MIN : RUN;
`else
    state_d = !mode_ev ? state_q : (state_q == RUN) ? SET_HR : (state_q == SET_HR) ? SET_MIN : RUN;
`endif
  end
  // field being edited, decoded straight from the state
  always_comb begin
    bus.field_sel = (state_q == SET_HR || state_q == SET_AL_HR) ? 2'b01 :
                    (state_q == SET_MIN || state_q == SET_AL_MIN) ? 2'b10 : 2'b00;
  end
  // prescaler, synchroniser and pm registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q <= '0;
      mode_sync_q <= '0;
      inc_sync_q <= '0;
      pm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mode_sync_q <= mode_sync_d;
      inc_sync_q <= inc_sync_d;
      pm_q <= pm_d;
    end
  assign bus.sec_bcd = sec;
  assign bus.min_bcd = min;
  assign bus.hr_bcd = (!H24 && hr == 8'h00) ? BCD_12 : hr;
  assign bus.pm = pm_q;
  assign bus.tick_1hz = tick;
`ifdef RTC_ALARM_EN
  logic al_pm_q, al_pm_d, ring_q, ring_d, al_hr_wrap, match;
  logic [7:0] al_hr, al_min, min_n, hr_n;
  bcd_mod_counter #(.MAX(HR_MAX)) u_al_hr (.clk(clk), .rst(rst), .inc((state_q == SET_AL_HR) && inc_act),
                                          .load(1'b0), .q(al_hr), .wrap(al_hr_wrap));
  bcd_mod_counter #(.MAX(BCD_59)) u_al_min (.clk(clk), .rst(rst), .inc((state_q == SET_AL_MIN) && inc_act),
                                           .load(1'b0), .q(al_min), .wrap());
  // compare against the time this tick is about to produce so ring rises with sec=00
  always_comb begin
    al_pm_d = H24 ? 1'b0 : al_pm_q ^ al_hr_wrap;
    min_n = min_wrap ? 8'h00 : bcd_inc8(min);
    hr_n = hr_inc ? (hr_wrap ? 8'h00 : bcd_inc8(hr)) : hr;
    match = sec_wrap && (min_n == al_min) && (hr_n == al_hr) && (pm_d == al_pm_q);
    ring_d = !bus.alarm_arm ? 1'b0 : (inc_act && state_q == RUN) ? 1'b0 : match ? 1'b1 : ring_q;
  end
  // alarm pm and ring registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      al_pm_q <= 1'b0;
      ring_q <= 1'b0;
    end else begin
      al_pm_q <= al_pm_d;
      ring_q <= ring_d;
    end
  assign bus.alarm_ring = ring_q;
  assign bus.al_active = (state_q == SET_AL_HR) || (state_q == SET_AL_MIN);
`endif
endmodule

// File: tb/tb_rtc_bcd_core.sv
// tb_rtc_bcd_core: scoreboard bench comparing 12h and 24h cores against a seconds-of-day reference model
module tb_rtc_bcd_core;
  localparam int CLK_HZ = 4;
`ifdef RTC_ALARM_EN
  localparam int NST = 5;
`else
  localparam int NST = 3;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run_en = 1'b0, bm = 1'b0, bi = 1'b0;
  always #5 clk = ~clk;
  rtc_bcd_core_if b12();
  rtc_bcd_core_if b24();
  assign b12.run_en = run_en;
  assign b12.btn_mode = bm;
  assign b12.btn_inc = bi;
  assign b24.run_en = run_en;
  assign b24.btn_mode = bm;
  assign b24.btn_inc = bi;
`ifdef RTC_ALARM_EN
  assign b12.alarm_arm = 1'b0;
  assign b24.alarm_arm = 1'b0;
`endif
  rtc_bcd_core #(.CLK_HZ(CLK_HZ), .H24(1'b0)) dut12 (.clk(clk), .rst(rst), .bus(b12));
  rtc_bcd_core #(.CLK_HZ(CLK_HZ), .H24(1'b1)) dut24 (.clk(clk), .rst(rst), .bus(b24));

  int vectors = 0, miscompares = 0;
  logic [27:0] q12[$], q24[$];
  int t = 0, mode = 0, presc = 0;
  logic [2:0] hm = '0, hi = '0;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  function automatic logic [27:0] exp_vec(input bit h24);
    int h = t / 3600;
    int hh = h24 ? h : ((h % 12 == 0) ? 12 : h % 12);
    logic [1:0] f = (mode == 1 || mode == 3) ? 2'b01 : (mode == 2 || mode == 4) ? 2'b10 : 2'b00;
    bit tk = run_en && mode == 0 && presc == CLK_HZ - 1;
    return {bcd(t % 60), bcd((t / 60) % 60), bcd(hh), (!h24 && h >= 12), f, tk};
  endfunction

  // reference model: time as seconds of day, buttons seen through a 3-deep sample history
  always @(posedge clk) begin
    if (!rst) begin
      t = 0; mode = 0; presc = 0; hm = '0; hi = '0;
    end else begin
      bit ma, ia, tk;
      ma = hm[1] & ~hm[2];
      ia = hi[1] & ~hi[2] & ~ma;
      tk = mode == 0 && run_en && presc == CLK_HZ - 1;
      if (mode == 0 && run_en) presc = tk ? 0 : presc + 1;
      if (tk) t = (t + 1) % 86400;
      if (ma) begin
        if (mode == 0) begin presc = 0; t = t - t % 60; end
        mode = (mode + 1) % NST;
      end else if (ia && mode == 1) t = (t + 3600) % 86400;
      else if (ia && mode == 2) t = (t / 3600) * 3600 + (((t / 60) % 60 + 1) % 60) * 60 + t % 60;
      hm = {hm[1:0], bm};
      hi = {hi[1:0], bi};
    end
    q12.push_back(exp_vec(1'b0));
    q24.push_back(exp_vec(1'b1));
  end

  task automatic check(input string n, input logic [27:0] got, input logic [27:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s @%0t got sec=%h min=%h hr=%h pm=%b sel=%b tick=%b want sec=%h min=%h hr=%h pm=%b sel=%b tick=%b",
               n, $time, got[27:20], got[19:12], got[11:4], got[3], got[2:1], got[0],
               want[27:20], want[19:12], want[11:4], want[3], want[2:1], want[0]);
    end
  endtask

  // monitor: pop one expected vector per DUT each cycle, away from the edge
  always @(posedge clk) begin
    #1;
    if (q12.size() == 0 || q24.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_empty @%0t got %0d/%0d entries want >0", $time, q12.size(), q24.size());
    end else begin
      check("h12", {b12.sec_bcd, b12.min_bcd, b12.hr_bcd, b12.pm, b12.field_sel, b12.tick_1hz}, q12.pop_front());
      check("h24", {b24.sec_bcd, b24.min_bcd, b24.hr_bcd, b24.pm, b24.field_sel, b24.tick_1hz}, q24.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit is_mode, input int hold = 2);
    if (is_mode) bm = 1'b1;
    else bi = 1'b1;
    cyc(hold);
    bm = 1'b0;
    bi = 1'b0;
    cyc(4);
  endtask

  initial begin
    cyc(3);
    rst = 1'b1;
    run_en = 1'b1;
    cyc(12);
    press(1'b1);
    repeat (3) press(1'b0);
    press(1'b1);
    repeat (61) press(1'b0);
    press(1'b1);
    cyc(10);
    press(1'b1);
    for (int i = 0; i < 24 && t / 3600 != 23; i++) press(1'b0);
    press(1'b1);
    for (int i = 0; i < 60 && (t / 60) % 60 != 59; i++) press(1'b0);
    press(1'b1);
    cyc(CLK_HZ * 61 + 4);
    press(1'b1);
    bm = 1'b1;
    bi = 1'b1;
    cyc(2);
    bm = 1'b0;
    bi = 1'b0;
    cyc(4);
    bi = 1'b1;
    cyc(100);
    bi = 1'b0;
    cyc(4);
    press(1'b1);
    cyc(10);
    run_en = 1'b0;
    cyc(20);
    run_en = 1'b1;
    cyc(6);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) bm = ~bm;
      if ($urandom_range(0, 9) == 0) bi = ~bi;
      if ($urandom_range(0, 29) == 0) run_en = ~run_en;
      cyc(1);
    end
    bm = 1'b0;
    bi = 1'b0;
    run_en = 1'b1;
    cyc(6);
    for (int i = 0; i < 6 && mode != 2; i++) press(1'b1);
    rst = 1'b0;
    #1;
    check("rst_async12", {b12.sec_bcd, b12.min_bcd, b12.hr_bcd, b12.pm, b12.field_sel, b12.tick_1hz},
          {8'h00, 8'h00, 8'h12, 1'b0, 2'b00, 1'b0});
    check("rst_async24", {b24.sec_bcd, b24.min_bcd, b24.hr_bcd, b24.pm, b24.field_sel, b24.tick_1hz},
          {8'h00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0});
    cyc(2);
    rst = 1'b1;
    cyc(CLK_HZ * 3 + 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
